// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the SRAM request controller.
package sram_ctrl_pkg;

  localparam int unsigned DefWidth      = 512;
  localparam int unsigned DefLogNumRows = 9;
  localparam int unsigned DefWordSize   = 64;
  localparam int unsigned DefTagW       = 4;
  localparam int unsigned NUM_WORDS     = DefWidth / DefWordSize;

  typedef struct packed {
    logic [DefWidth-1:0] data;
    logic [DefTagW-1:0]  tag;
  } rsp_entry_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO of rsp_entry_t with an occupancy count.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  rsp_entry_t      push_entry,
  input  logic            pop,
  output rsp_entry_t      pop_entry,
  output logic [CntW-1:0] count
);

  rsp_entry_t            mem_q [DEPTH];
  logic       [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic       [CntW-1:0] count_q;
  logic                  do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign do_pop  = pop && (count_q != '0);
  // Full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign pop_entry = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/sram_req_ctrl.sv
// Request-side controller for a 1R1W SRAM with tagged, credit-limited read responses.
// Define SRAM_CTRL_FWD_EN to forward same-cycle same-address write data into the read response.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned LOG_NUM_ROWS = DefLogNumRows,
  parameter int unsigned WORD_SIZE    = DefWordSize,
  parameter int unsigned TAG_W        = DefTagW,
  parameter int unsigned RSP_DEPTH    = 2,
  localparam int unsigned NumWords    = WIDTH / WORD_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rdReqValid,
  output logic                    rdReqReady,
  input  logic [LOG_NUM_ROWS-1:0] rdReqAddr,
  input  logic [TAG_W-1:0]        rdReqTag,
  output logic                    rdRspValid,
  input  logic                    rdRspReady,
  output logic [WIDTH-1:0]        rdRspData,
  output logic [TAG_W-1:0]        rdRspTag,
  input  logic                    wrReqValid,
  output logic                    wrReqReady,
  input  logic [LOG_NUM_ROWS-1:0] wrReqAddr,
  input  logic [WIDTH-1:0]        wrReqData,
  input  logic [NumWords-1:0]     wrReqMask,
  output logic [LOG_NUM_ROWS-1:0] sramReadAddr,
  input  logic [WIDTH-1:0]        sramReadData,
  output logic [LOG_NUM_ROWS-1:0] sramWriteAddr,
  output logic [WIDTH-1:0]        sramWriteData,
  output logic [NumWords-1:0]     sramWriteEnable
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  logic             wr_acc, rd_acc;
  logic             inflight_q;
  logic [TAG_W-1:0] tag_q;
  logic [CntW-1:0]  q_count;
  logic [CntW:0]    used;
  logic [WIDTH-1:0] capture_data;
  rsp_entry_t       push_entry, pop_entry;

  assign wrReqReady      = !reset;
  assign wr_acc          = wrReqValid && wrReqReady;
  assign sramWriteAddr   = wrReqAddr;
  assign sramWriteData   = wrReqData;
  assign sramWriteEnable = wr_acc ? wrReqMask : '0;

  // Credits cover queued entries plus the read whose data is still in the SRAM.
  assign used         = {1'b0, q_count} + (CntW + 1)'(inflight_q);
  assign rdReqReady   = !reset && (used < (CntW + 1)'(RSP_DEPTH));
  assign rd_acc       = rdReqValid && rdReqReady;
  assign sramReadAddr = rdReqAddr;

  always_ff @(posedge clk) begin
    if (reset) inflight_q <= 1'b0;
    else       inflight_q <= rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rd_acc) tag_q <= rdReqTag;
  end

`ifdef SRAM_CTRL_FWD_EN
  logic                fwd_q;
  logic [WIDTH-1:0]    fwd_data_q;
  logic [NumWords-1:0] fwd_mask_q;

  always_ff @(posedge clk) begin
    if (reset) fwd_q <= 1'b0;
    else       fwd_q <= rd_acc && wr_acc && (rdReqAddr == wrReqAddr);
  end

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      fwd_data_q <= wrReqData;
      fwd_mask_q <= wrReqMask;
    end
  end

  always_comb begin
    capture_data = sramReadData;
    if (fwd_q) begin
      for (int w = 0; w < NumWords; w++) begin
        if (fwd_mask_q[w]) capture_data[w*WORD_SIZE +: WORD_SIZE] = fwd_data_q[w*WORD_SIZE +: WORD_SIZE];
      end
    end
  end
`else
  assign capture_data = sramReadData;
`endif

  always_comb begin
    push_entry      = '0;
    push_entry.data = capture_data;
    push_entry.tag  = tag_q;
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight_q),
    .push_entry (push_entry),
    .pop        (rdRspValid && rdRspReady),
    .pop_entry  (pop_entry),
    .count      (q_count)
  );

  assign rdRspValid = !reset && (q_count != '0);
  assign rdRspData  = pop_entry.data;
  assign rdRspTag   = pop_entry.tag;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Scoreboard bench for sram_req_ctrl: directed cases followed by random traffic vs a reference memory.
module tb_sram_req_ctrl;

  localparam int WIDTH     = 512;
  localparam int LOG_ROWS  = 9;
  localparam int WS        = 64;
  localparam int TAG_W     = 4;
  localparam int RSP_DEPTH = 2;
  localparam int NW        = WIDTH / WS;
  localparam int ROWS      = 2 ** LOG_ROWS;

  logic                clk, reset;
  logic                rdReqValid, rdReqReady, rdRspValid, rdRspReady;
  logic [LOG_ROWS-1:0] rdReqAddr, wrReqAddr, sramReadAddr, sramWriteAddr;
  logic [TAG_W-1:0]    rdReqTag, rdRspTag;
  logic [WIDTH-1:0]    rdRspData, wrReqData, sramReadData, sramWriteData;
  logic                wrReqValid, wrReqReady;
  logic [NW-1:0]       wrReqMask, sramWriteEnable;

  sram_req_ctrl #(
    .WIDTH        (WIDTH),
    .LOG_NUM_ROWS (LOG_ROWS),
    .WORD_SIZE    (WS),
    .TAG_W        (TAG_W),
    .RSP_DEPTH    (RSP_DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rdReqValid      (rdReqValid),
    .rdReqReady      (rdReqReady),
    .rdReqAddr       (rdReqAddr),
    .rdReqTag        (rdReqTag),
    .rdRspValid      (rdRspValid),
    .rdRspReady      (rdRspReady),
    .rdRspData       (rdRspData),
    .rdRspTag        (rdRspTag),
    .wrReqValid      (wrReqValid),
    .wrReqReady      (wrReqReady),
    .wrReqAddr       (wrReqAddr),
    .wrReqData       (wrReqData),
    .wrReqMask       (wrReqMask),
    .sramReadAddr    (sramReadAddr),
    .sramReadData    (sramReadData),
    .sramWriteAddr   (sramWriteAddr),
    .sramWriteData   (sramWriteData),
    .sramWriteEnable (sramWriteEnable)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] sram_mem [ROWS];
  logic [WIDTH-1:0] ref_mem  [ROWS];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_row();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_row,
                                              input logic [WIDTH-1:0] new_row,
                                              input logic [NW-1:0] mask);
    logic [WIDTH-1:0] r;
    r = old_row;
    for (int w = 0; w < NW; w++) if (mask[w]) r[w*WS +: WS] = new_row[w*WS +: WS];
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM: registered read sees contents before this edge's write.
  initial begin
    logic [WIDTH-1:0] v;
    for (int i = 0; i < ROWS; i++) begin
      v = (i == 0) ? WIDTH'(32'hffff_ffff) : rand_row();
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    forever begin
      @(posedge clk);
      sramReadData <= sram_mem[sramReadAddr];
      for (int w = 0; w < NW; w++)
        if (sramWriteEnable[w]) sram_mem[sramWriteAddr][w*WS +: WS] = sramWriteData[w*WS +: WS];
    end
  end

  // Scoreboard: push expected on read accept, pop and compare on response handshake.
  initial begin
    exp_t             e;
    logic             prev_hold;
    logic [WIDTH-1:0] prev_data;
    logic [TAG_W-1:0] prev_tag;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_tag  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && rdRspValid) begin
          chk_row("held rsp data", rdRspData, prev_data);
          chk_int("held rsp tag", int'(rdRspTag), int'(prev_tag));
        end
        if (rdReqValid && rdReqReady) begin
          e.tag  = rdReqTag;
`ifdef SRAM_CTRL_FWD_EN
          if (wrReqValid && wrReqReady && wrReqAddr == rdReqAddr)
            e.data = merge(ref_mem[rdReqAddr], wrReqData, wrReqMask);
          else
            e.data = ref_mem[rdReqAddr];
`else
          e.data = ref_mem[rdReqAddr];
`endif
          sb.push_back(e);
        end
        if (wrReqValid && wrReqReady)
          ref_mem[wrReqAddr] = merge(ref_mem[wrReqAddr], wrReqData, wrReqMask);
        if (rdRspValid && rdRspReady) begin
          if (sb.size() == 0) begin
            chk_int("unexpected response", 1, 0);
          end else begin
            e = sb.pop_front();
            chk_row("rsp data", rdRspData, e.data);
            chk_int("rsp tag", int'(rdRspTag), int'(e.tag));
          end
        end
        prev_hold = rdRspValid && !rdRspReady;
        prev_data = rdRspData;
        prev_tag  = rdRspTag;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdReqValid = 1'b0;
    wrReqValid = 1'b0;
    wrReqMask  = '0;
  endtask

  initial begin
    int acc;
    reset      = 1'b1;
    idle();
    rdReqAddr  = '0;
    rdReqTag   = '0;
    wrReqAddr  = '0;
    wrReqData  = '0;
    rdRspReady = 1'b1;
    // Write requested during reset must not reach the SRAM.
    wrReqValid = 1'b1;
    wrReqMask  = '1;
    rdReqValid = 1'b1;
    step();
    @(negedge clk);
    chk_int("reset rdReqReady", int'(rdReqReady), 0);
    chk_int("reset wrReqReady", int'(wrReqReady), 0);
    chk_int("reset rdRspValid", int'(rdRspValid), 0);
    chk_int("reset sramWriteEnable", int'(sramWriteEnable), 0);
    step();
    reset = 1'b0;
    idle();

    // Read row 0: response two cycles after accept.
    rdReqValid = 1'b1;
    rdReqAddr  = 9'd0;
    rdReqTag   = 4'd3;
    @(negedge clk);
    chk_int("first read ready", int'(rdReqReady), 1);
    step();
    idle();
    @(negedge clk);
    chk_int("rsp valid at N+1", int'(rdRspValid), 0);
    step();
    @(negedge clk);
    chk_int("rsp valid at N+2", int'(rdRspValid), 1);
    step();

    // Partial write then read of the same row next cycle.
    wrReqValid = 1'b1;
    wrReqAddr  = 9'd5;
    wrReqMask  = 8'h01;
    wrReqData  = WIDTH'(64'hDEAD);
    step();
    idle();
    rdReqValid = 1'b1;
    rdReqAddr  = 9'd5;
    rdReqTag   = 4'd5;
    step();
    idle();
    repeat (4) step();

    // Backpressure: only RSP_DEPTH reads accepted.
    rdRspReady = 1'b0;
    acc        = 0;
    for (int i = 0; i < 6; i++) begin
      rdReqValid = 1'b1;
      rdReqAddr  = LOG_ROWS'(i + 10);
      rdReqTag   = TAG_W'(i);
      @(negedge clk);
      if (rdReqReady) acc++;
      step();
    end
    idle();
    @(negedge clk);
    chk_int("accepted under backpressure", acc, RSP_DEPTH);
    chk_int("ready low when credits used", int'(rdReqReady), 0);
    step();
    rdRspReady = 1'b1;
    repeat (6) step();

    // Same-cycle write and read of row 7.
    wrReqValid = 1'b1;
    wrReqAddr  = 9'd7;
    wrReqMask  = 8'hFF;
    wrReqData  = {64{8'hA5}};
    rdReqValid = 1'b1;
    rdReqAddr  = 9'd7;
    rdReqTag   = 4'd7;
    step();
    idle();
    repeat (4) step();

    // Reset with a queued response and one read in flight.
    rdRspReady = 1'b0;
    rdReqValid = 1'b1;
    rdReqAddr  = 9'd1;
    rdReqTag   = 4'd9;
    step();
    rdReqTag   = 4'd10;
    step();
    idle();
    @(negedge clk);
    chk_int("queued before reset", int'(rdRspValid), 1);
    reset = 1'b1;
    step();
    @(negedge clk);
    chk_int("rsp valid in reset", int'(rdRspValid), 0);
    step();
    reset      = 1'b0;
    rdRspReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_int("no stale rsp after reset", int'(rdRspValid), 0);
      step();
    end

    // Random traffic on a small address window to provoke collisions.
    for (int i = 0; i < 10000; i++) begin
      rdReqValid = ($urandom_range(0, 99) < 50);
      rdReqAddr  = LOG_ROWS'($urandom_range(0, 15));
      rdReqTag   = TAG_W'($urandom);
      wrReqValid = ($urandom_range(0, 99) < 40);
      wrReqAddr  = LOG_ROWS'($urandom_range(0, 15));
      wrReqMask  = NW'($urandom);
      wrReqData  = rand_row();
      rdRspReady = ($urandom_range(0, 99) < 70);
      step();
    end
    idle();
    rdRspReady = 1'b1;
    repeat (10) step();
    @(negedge clk);
    chk_int("responses outstanding at end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
